// File: rtl/sp_drive_serdes_if.sv
// Byte-side bus between the drive-emulation command logic and the serdes.
// The command logic is the master: it offers bytes to transmit and consumes
// received bytes. The serdes is the slave.
interface sp_drive_serdes_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_synced;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_underrun;

    modport master (
        input  rx_data,
        input  rx_valid,
        input  rx_synced,
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy,
        input  tx_underrun
    );

    modport slave (
        output rx_data,
        output rx_valid,
        output rx_synced,
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy,
        output tx_underrun
    );
endinterface

// File: rtl/sp_drive_serdes.sv
// Drive-side bit-level endpoint of the SmartPort/Disk II serial link.
// Receive: transition-encoded wrdata (one transition = 1 bit, long silence =
// 0 bits) is decoded and framed into bytes while the host writes.
// Transmit: bytes are sent MSB-first on rddata, a low pulse per 1 bit, while
// the host reads. Both directions share the single fclk domain.
module sp_drive_serdes #(
    parameter int BIT_CELL    = 28,
    parameter int HALF_CELL   = 14,
    parameter int ZERO_THRESH = 42,
    parameter int PULSE_LEN   = 7
) (
    input  logic             fclk,
    input  logic             nRES,
    input  logic             enable,
    input  logic             _wrreq,
    input  logic             wrdata,
    output logic             rddata,
    sp_drive_serdes_if.slave bus
);
    localparam logic [7:0] HALF_T    = 8'(HALF_CELL);
    localparam logic [7:0] ZERO_T    = 8'(ZERO_THRESH);
    localparam logic [7:0] CELL_LAST = 8'(BIT_CELL - 1);
    localparam logic [7:0] PULSE_T   = 8'(PULSE_LEN);

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } txState_t;

    // Direction enables; _wrreq selects exactly one of them.
    logic rxEn;
    logic txEn;

    // Receive path state
    logic       wrSync1;
    logic       wrSync2;
    logic       wrEdge;
    logic [7:0] rxTimer;
    logic [7:0] rxTimerNext;
    logic       bitStrobe;
    logic       bitValue;
    logic [7:0] rxShift;
    logic [2:0] rxBitCnt;
    logic [2:0] rxOnesCnt;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxSynced;

    // Transmit path state
    txState_t   txState;
    logic [7:0] txShift;
    logic [7:0] txTimer;
    logic [2:0] txIdx;
    logic       rdReg;
    logic       txUnderrun;
    logic       txReady;
    logic       cellEnd;

    assign rxEn    = enable & ~_wrreq;
    assign txEn    = enable & _wrreq;
    assign wrEdge  = wrSync1 ^ wrSync2;
    assign cellEnd = (txTimer == CELL_LAST);

    // A new byte may enter from idle, or exactly at the last cycle of bit 7
    // so back-to-back bytes keep a constant 8-cell byte period.
    assign txReady = (txState == TX_IDLE) ? txEn
                                          : (txEn && (txIdx == 3'd7) && cellEnd);

    assign rddata          = rdReg;
    assign bus.rx_data     = rxData;
    assign bus.rx_valid    = rxValid;
    assign bus.rx_synced   = rxSynced;
    assign bus.tx_ready    = txReady;
    assign bus.tx_busy     = (txState == TX_SHIFT);
    assign bus.tx_underrun = txUnderrun;

    // Two-flop synchroniser for the asynchronous host write data.
    always_ff @(posedge fclk or negedge nRES) begin
        if (!nRES) begin
            wrSync1 <= 1'b0;
            wrSync2 <= 1'b0;
        end else begin
            wrSync1 <= wrdata;
            wrSync2 <= wrSync1;
        end
    end

    // Bit decoder: a well-spaced transition is a 1, silence past the
    // threshold is a 0; a transition at the threshold still counts as a 1.
    always_comb begin
        bitStrobe   = 1'b0;
        bitValue    = 1'b0;
        rxTimerNext = rxTimer + 8'd1;
        if (wrEdge) begin
            if (rxTimer >= HALF_T) begin
                bitStrobe   = 1'b1;
                bitValue    = 1'b1;
                rxTimerNext = 8'd0;
            end
        end else if (rxTimer == ZERO_T) begin
            bitStrobe   = 1'b1;
            bitValue    = 1'b0;
            rxTimerNext = HALF_T;
        end
    end

    // Byte framing: hunt for eight consecutive 1s, then collect 8-bit bytes.
    always_ff @(posedge fclk or negedge nRES) begin
        if (!nRES) begin
            rxTimer   <= 8'd0;
            rxShift   <= 8'd0;
            rxBitCnt  <= 3'd0;
            rxOnesCnt <= 3'd0;
            rxData    <= 8'd0;
            rxValid   <= 1'b0;
            rxSynced  <= 1'b0;
        end else if (!rxEn) begin
            rxTimer   <= 8'd0;
            rxShift   <= 8'd0;
            rxBitCnt  <= 3'd0;
            rxOnesCnt <= 3'd0;
            rxValid   <= 1'b0;
            rxSynced  <= 1'b0;
        end else begin
            rxTimer <= rxTimerNext;
            rxValid <= 1'b0;
            if (bitStrobe) begin
                if (!rxSynced) begin
                    if (bitValue) begin
                        if (rxOnesCnt == 3'd7) begin
                            rxData    <= 8'hFF;
                            rxValid   <= 1'b1;
                            rxSynced  <= 1'b1;
                            rxBitCnt  <= 3'd0;
                            rxShift   <= 8'd0;
                            rxOnesCnt <= 3'd0;
                        end else begin
                            rxOnesCnt <= rxOnesCnt + 3'd1;
                        end
                    end else begin
                        rxOnesCnt <= 3'd0;
                    end
                end else if (rxBitCnt == 3'd7) begin
                    rxData   <= {rxShift[6:0], bitValue};
                    rxValid  <= 1'b1;
                    rxShift  <= 8'd0;
                    rxBitCnt <= 3'd0;
                end else begin
                    rxShift  <= {rxShift[6:0], bitValue};
                    rxBitCnt <= rxBitCnt + 3'd1;
                end
            end
        end
    end

    // Serialiser FSM: one cell per bit, low pulse at cell start for a 1.
    always_ff @(posedge fclk or negedge nRES) begin
        if (!nRES) begin
            txState    <= TX_IDLE;
            txShift    <= 8'd0;
            txTimer    <= 8'd0;
            txIdx      <= 3'd0;
            rdReg      <= 1'b1;
            txUnderrun <= 1'b0;
        end else begin
            case (txState)
                TX_IDLE: begin
                    rdReg <= 1'b1;
                    if (bus.tx_valid && txReady) begin
                        txShift    <= bus.tx_data;
                        txIdx      <= 3'd0;
                        txTimer    <= 8'd0;
                        txUnderrun <= 1'b0;
                        txState    <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (!txEn) begin
                        // Host turned the bus around: drop the byte at once.
                        rdReg   <= 1'b1;
                        txState <= TX_IDLE;
                        txTimer <= 8'd0;
                        txIdx   <= 3'd0;
                        txShift <= 8'd0;
                    end else begin
                        if ((txTimer == 8'd0) && txShift[7]) begin
                            rdReg <= 1'b0;
                        end else if (txTimer == PULSE_T) begin
                            rdReg <= 1'b1;
                        end
                        if (cellEnd) begin
                            txTimer <= 8'd0;
                            if (txIdx == 3'd7) begin
                                if (bus.tx_valid) begin
                                    txShift <= bus.tx_data;
                                    txIdx   <= 3'd0;
                                end else begin
                                    txUnderrun <= 1'b1;
                                    rdReg      <= 1'b1;
                                    txState    <= TX_IDLE;
                                    txShift    <= 8'd0;
                                    txIdx      <= 3'd0;
                                end
                            end else begin
                                txShift <= {txShift[6:0], 1'b0};
                                txIdx   <= txIdx + 3'd1;
                            end
                        end else begin
                            txTimer <= txTimer + 8'd1;
                        end
                    end
                end
                default: txState <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sp_drive_serdes.sv
// Directed bench for sp_drive_serdes: receive framing, glitch rejection and
// zero insertion, back-to-back transmit timing, underrun, bus turnaround and
// asynchronous reset.
module tb_sp_drive_serdes;
    logic fclk   = 1'b0;
    logic nRES   = 1'b0;
    logic enable = 1'b0;
    logic _wrreq = 1'b1;
    logic wrdata = 1'b0;
    logic rddata;

    sp_drive_serdes_if bus ();

    sp_drive_serdes dut (
        .fclk   (fclk),
        .nRES   (nRES),
        .enable (enable),
        ._wrreq (_wrreq),
        .wrdata (wrdata),
        .rddata (rddata),
        .bus    (bus)
    );

    always #5 fclk = ~fclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Cycle stamp, advanced on every active edge
    always @(posedge fclk) cyc <= cyc + 1;

    // Received-byte log, sampled on the inactive edge
    logic [7:0] rxQ[$];
    int         rxCycQ[$];
    logic       rxSyncQ[$];
    always @(negedge fclk) begin
        if (bus.rx_valid === 1'b1) begin
            rxQ.push_back(bus.rx_data);
            rxCycQ.push_back(cyc);
            rxSyncQ.push_back(bus.rx_synced);
            $display("rx byte %02h at cycle %0d", bus.rx_data, cyc);
        end
    end

    // rddata pulse log: start cycle and low length of every pulse
    int   pulseStart[$];
    int   pulseLen[$];
    int   curLen = 0;
    logic prevRd = 1'b1;
    always @(negedge fclk) begin
        if (rddata === 1'b0) begin
            if (prevRd) begin
                pulseStart.push_back(cyc);
                curLen = 0;
            end
            curLen++;
        end else if (!prevRd) begin
            pulseLen.push_back(curLen);
        end
        prevRd = rddata;
    end

    task automatic toggle_wr();
        wrdata = ~wrdata;
    endtask

    task automatic test_reset();
        nRES = 1'b0;
        repeat (3) @(negedge fclk);
        total++; if (rddata !== 1'b1) begin bad++; $display("FAIL reset_rddata: got %b want 1", rddata); end
        total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        total++; if (bus.rx_synced !== 1'b0) begin bad++; $display("FAIL reset_rx_synced: got %b want 0", bus.rx_synced); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy: got %b want 0", bus.tx_busy); end
        total++; if (bus.tx_underrun !== 1'b0) begin bad++; $display("FAIL reset_tx_underrun: got %b want 0", bus.tx_underrun); end
        nRES = 1'b1;
        @(negedge fclk);
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL disabled_tx_ready: got %b want 0", bus.tx_ready); end
        $display("reset released at cycle %0d", cyc);
    endtask

    // Eight ones spaced one cell apart, then 00111111 on the same cell grid
    task automatic test_rx_sync_data();
        rxQ.delete(); rxCycQ.delete(); rxSyncQ.delete();
        enable = 1'b1;
        _wrreq = 1'b0;
        repeat (20) @(negedge fclk);
        for (int i = 0; i < 8; i++) begin
            toggle_wr();
            repeat (28) @(negedge fclk);
        end
        repeat (56) @(negedge fclk);
        for (int i = 0; i < 6; i++) begin
            toggle_wr();
            repeat (28) @(negedge fclk);
        end
        total++; if (rxQ.size() != 2) begin bad++; $display("FAIL rx_sync_count: got %0d want 2", rxQ.size()); end
        if (rxQ.size() >= 2) begin
            total++; if (rxQ[0] !== 8'hFF) begin bad++; $display("FAIL rx_sync_byte: got %h want ff", rxQ[0]); end
            total++; if (rxSyncQ[0] !== 1'b1) begin bad++; $display("FAIL rx_synced_set: got %b want 1", rxSyncQ[0]); end
            total++; if (rxQ[1] !== 8'h3F) begin bad++; $display("FAIL rx_data_3f: got %h want 3f", rxQ[1]); end
            total++; if (rxCycQ[1] - rxCycQ[0] != 224) begin bad++; $display("FAIL rx_3f_spacing: got %0d want 224", rxCycQ[1] - rxCycQ[0]); end
        end
    endtask

    // 1, 1 with a glitch 5 cycles after the first, 140-cycle gap (four
    // inserted zeros then a 1), final 1: byte 1100_0011
    task automatic test_rx_glitch_zero();
        toggle_wr();
        repeat (5) @(negedge fclk);
        toggle_wr();
        repeat (23) @(negedge fclk);
        toggle_wr();
        repeat (140) @(negedge fclk);
        toggle_wr();
        repeat (28) @(negedge fclk);
        toggle_wr();
        repeat (10) @(negedge fclk);
        total++; if (rxQ.size() != 3) begin bad++; $display("FAIL rx_glitch_count: got %0d want 3", rxQ.size()); end
        if (rxQ.size() >= 3) begin
            total++; if (rxQ[2] !== 8'hC3) begin bad++; $display("FAIL rx_data_c3: got %h want c3", rxQ[2]); end
            total++; if (rxCycQ[2] - rxCycQ[1] != 224) begin bad++; $display("FAIL rx_c3_spacing: got %0d want 224", rxCycQ[2] - rxCycQ[1]); end
        end
        _wrreq = 1'b1;
        @(negedge fclk);
        total++; if (bus.rx_synced !== 1'b0) begin bad++; $display("FAIL rx_disable_synced: got %b want 0", bus.rx_synced); end
        total++; if (bus.rx_data !== 8'hC3) begin bad++; $display("FAIL rx_disable_hold: got %h want c3", bus.rx_data); end
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        int expOff[12];
        expOff = '{0, 28, 56, 84, 112, 140, 168, 196, 224, 252, 392, 420};
        t1 = -1;
        t2 = -1;
        enable = 1'b1;
        _wrreq = 1'b1;
        repeat (3) @(negedge fclk);
        pulseStart.delete(); pulseLen.delete();
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus.tx_ready === 1'b1) begin t1 = cyc; break; end
            @(negedge fclk);
        end
        @(negedge fclk);
        $display("tx accept ff at cycle %0d", t1);
        bus.tx_data = 8'hC3;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus.tx_ready === 1'b1) begin t2 = cyc; break; end
            @(negedge fclk);
        end
        @(negedge fclk);
        bus.tx_valid = 1'b0;
        $display("tx accept c3 at cycle %0d", t2);
        total++; if (t1 < 0 || t2 < 0) begin bad++; $display("FAIL b2b_ready_timeout: got t1=%0d t2=%0d want both seen", t1, t2); end
        total++; if (t2 - t1 != 224) begin bad++; $display("FAIL b2b_ready_spacing: got %0d want 224", t2 - t1); end
        total++; if (bus.tx_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", bus.tx_busy); end
        repeat (240) @(negedge fclk);
        total++; if (pulseStart.size() != 12 || pulseLen.size() != 12) begin bad++; $display("FAIL b2b_pulse_count: got %0d/%0d want 12", pulseStart.size(), pulseLen.size()); end
        if (pulseStart.size() == 12 && pulseLen.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                total++; if (pulseStart[i] != t1 + 2 + expOff[i]) begin bad++; $display("FAIL b2b_pulse_start[%0d]: got %0d want %0d", i, pulseStart[i], t1 + 2 + expOff[i]); end
                total++; if (pulseLen[i] != 7) begin bad++; $display("FAIL b2b_pulse_len[%0d]: got %0d want 7", i, pulseLen[i]); end
            end
        end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_end_busy: got %b want 0", bus.tx_busy); end
        total++; if (rddata !== 1'b1) begin bad++; $display("FAIL b2b_end_rddata: got %b want 1", rddata); end
    endtask

    task automatic test_underrun();
        int t;
        int tu;
        t  = -1;
        tu = -1;
        pulseStart.delete(); pulseLen.delete();
        bus.tx_data  = 8'h80;
        bus.tx_valid = 1'b1;
        #1;
        if (bus.tx_ready === 1'b1) t = cyc;
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL ur_idle_ready: got %b want 1", bus.tx_ready); end
        @(negedge fclk);
        bus.tx_valid = 1'b0;
        $display("tx accept 80 at cycle %0d", t);
        total++; if (bus.tx_underrun !== 1'b0) begin bad++; $display("FAIL ur_cleared_on_load: got %b want 0", bus.tx_underrun); end
        for (int i = 0; i < 300; i++) begin
            @(negedge fclk);
            if (bus.tx_underrun === 1'b1) begin tu = cyc; break; end
        end
        total++; if (tu != t + 225) begin bad++; $display("FAIL ur_set_cycle: got %0d want %0d", tu, t + 225); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL ur_busy: got %b want 0", bus.tx_busy); end
        total++; if (rddata !== 1'b1) begin bad++; $display("FAIL ur_rddata: got %b want 1", rddata); end
        repeat (30) @(negedge fclk);
        total++; if (pulseStart.size() != 1 || pulseLen.size() != 1) begin bad++; $display("FAIL ur_pulse_count: got %0d want 1", pulseStart.size()); end
        if (pulseLen.size() == 1) begin
            total++; if (pulseLen[0] != 7) begin bad++; $display("FAIL ur_pulse_len: got %0d want 7", pulseLen[0]); end
        end
    endtask

    task automatic test_direction_switch();
        bit seen;
        seen = 1'b0;
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge fclk);
        @(negedge fclk);
        bus.tx_valid = 1'b0;
        total++; if (bus.tx_underrun !== 1'b0) begin bad++; $display("FAIL dir_load_underrun: got %b want 0", bus.tx_underrun); end
        for (int i = 0; i < 100; i++) begin
            if (rddata === 1'b0) begin seen = 1'b1; break; end
            @(negedge fclk);
        end
        total++; if (!seen) begin bad++; $display("FAIL dir_pulse_timeout: got no pulse want pulse"); end
        _wrreq = 1'b0;
        $display("bus turnaround at cycle %0d", cyc);
        @(negedge fclk);
        total++; if (rddata !== 1'b1) begin bad++; $display("FAIL dir_rddata: got %b want 1", rddata); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL dir_busy: got %b want 0", bus.tx_busy); end
        total++; if (bus.tx_underrun !== 1'b0) begin bad++; $display("FAIL dir_underrun: got %b want 0", bus.tx_underrun); end
        total++; if (bus.rx_synced !== 1'b0) begin bad++; $display("FAIL dir_rx_synced: got %b want 0", bus.rx_synced); end
        repeat (40) @(negedge fclk);
        total++; if (rddata !== 1'b1) begin bad++; $display("FAIL dir_rddata_later: got %b want 1", rddata); end
        total++; if (bus.tx_underrun !== 1'b0) begin bad++; $display("FAIL dir_underrun_later: got %b want 0", bus.tx_underrun); end
        _wrreq = 1'b1;
        repeat (3) @(negedge fclk);
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 1'b0;
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
        @(negedge fclk);
        @(negedge fclk);
        bus.tx_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rddata === 1'b0) begin seen = 1'b1; break; end
            @(negedge fclk);
        end
        total++; if (!seen) begin bad++; $display("FAIL rst_pulse_timeout: got no pulse want pulse"); end
        #2;
        nRES = 1'b0;
        #1;
        $display("async reset asserted mid-pulse at cycle %0d", cyc);
        total++; if (rddata !== 1'b1) begin bad++; $display("FAIL rst_mid_rddata: got %b want 1", rddata); end
        total++; if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", bus.tx_busy); end
        total++; if (bus.rx_synced !== 1'b0) begin bad++; $display("FAIL rst_mid_synced: got %b want 0", bus.rx_synced); end
        @(negedge fclk);
        nRES = 1'b1;
        repeat (2) @(negedge fclk);
    endtask

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        test_reset();
        test_rx_sync_data();
        test_rx_glitch_zero();
        test_back_to_back();
        test_underrun();
        test_direction_switch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
